// File: rtl/sound_out.sv
`default_nettype none
// ============================================================================
//  Module   : sound_out
//  Purpose  : Square-wave beeper. While a beep is requested the speaker
//             toggles every TONE_HALF clocks (high half first). Each beep
//             lasts at least MIN_PERIODS whole periods, and a released beep
//             always finishes the period in progress, so the tone never ends
//             on a truncated half-wave. mute silences at once.
//  Ports    : SYS_CLK  - system clock, rising edge
//             reset    - synchronous, active-high reset
//             active   - beep request (level)
//             mute     - forced silence (level)
//             speaker  - registered tone output
//             busy     - high while not IDLE
//             periods  - whole periods of current/last beep, saturates at 255
//  Revision : 1.0 - initial release
// ============================================================================
module sound_out #(
  parameter int unsigned TONE_HALF   = 56818,
  parameter int unsigned MIN_PERIODS = 4
) (
  input  logic       SYS_CLK,
  input  logic       reset,
  input  logic       active,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [7:0] periods
);

  localparam logic [19:0] HALF_LAST = 20'(TONE_HALF - 1);
  localparam logic [7:0]  MIN_P     = 8'(MIN_PERIODS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TONE  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] half_ctr_q, half_ctr_d;
  logic        speaker_q, speaker_d;
  logic [7:0]  periods_q, periods_d;

  logic        half_wrap;
  logic        period_done;
  logic [7:0]  periods_inc;

  assign half_wrap   = (half_ctr_q == HALF_LAST);
  // A period completes when the low half expires.
  assign period_done = half_wrap && !speaker_q;
  assign periods_inc = (periods_q == 8'hFF) ? periods_q : periods_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    half_ctr_d = half_ctr_q;
    speaker_d  = speaker_q;
    periods_d  = periods_q;

    case (state_q)
      IDLE: begin
        speaker_d  = 1'b0;
        half_ctr_d = 20'd0;
        if (active && !mute) begin
          state_d   = TONE;
          speaker_d = 1'b1;
          periods_d = 8'd0;
        end
      end

      TONE, DRAIN: begin
        if (mute) begin
          state_d    = IDLE;
          speaker_d  = 1'b0;
          half_ctr_d = 20'd0;
        end else begin
          half_ctr_d = half_wrap ? 20'd0 : half_ctr_q + 20'd1;
          if (half_wrap) begin
            speaker_d = ~speaker_q;
          end
          if (period_done) begin
            periods_d = periods_inc;
          end

          if (state_q == TONE) begin
            // The release test counts a period finishing on this same edge;
            // at a period boundary there is nothing left to drain, so the
            // beep ends immediately instead of draining a whole extra period.
            if (!active && (periods_d >= MIN_P)) begin
              if (period_done) begin
                state_d    = IDLE;
                speaker_d  = 1'b0;
                half_ctr_d = 20'd0;
              end else begin
                state_d = DRAIN;
              end
            end
          end else begin
            // Re-request while draining resumes the tone with its phase intact.
            if (active) begin
              state_d = TONE;
            end else if (period_done) begin
              state_d    = IDLE;
              speaker_d  = 1'b0;
              half_ctr_d = 20'd0;
            end
          end
        end
      end

      default: begin
        state_d    = IDLE;
        speaker_d  = 1'b0;
        half_ctr_d = 20'd0;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      half_ctr_q <= 20'd0;
      speaker_q  <= 1'b0;
      periods_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      half_ctr_q <= half_ctr_d;
      speaker_q  <= speaker_d;
      periods_q  <= periods_d;
    end
  end

  assign speaker = speaker_q;
  assign busy    = (state_q != IDLE);
  assign periods = periods_q;

endmodule
`default_nettype wire
